// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ page scheduler: pointer width, page-size
// encodings, the ring wrap mask helper and the control FSM states.
package daq_pkg;

    localparam int unsigned LOG2_MAX_PAGES = 6;

    // page_size encodings; anything at or above PS_2048 selects the 16-page ring
    localparam logic [1:0] PS_512  = 2'd0;
    localparam logic [1:0] PS_1024 = 2'd1;
    localparam logic [1:0] PS_2048 = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Low-bit mask selecting log2(N) pointer bits for the given page size
    function automatic logic [LOG2_MAX_PAGES-1:0] n_pages_mask(input logic [1:0] ps);
        logic [LOG2_MAX_PAGES-1:0] all_ones;
        all_ones = '1;
        if (ps == PS_512)  return all_ones;
        if (ps == PS_1024) return all_ones >> 1;
        return all_ones >> 2;
    endfunction

endpackage

// File: rtl/daq_page_scheduler_if.sv
// Control/status bundle between the page scheduler and its clients.
//   master : drives page_size, flush, commit, release_dma, release_sw,
//            bundle_factor; observes the pointer/status outputs.
//   slave  : the scheduler itself.
interface daq_page_scheduler_if #(
    parameter int unsigned LOG2_MAX_PAGES = 6,
    parameter int unsigned DROP_W         = 16
);
    logic [1:0]                page_size;
    logic                      flush;
    logic                      commit;
    logic                      release_dma;
    logic                      release_sw;
    logic [3:0]                bundle_factor;
    logic [LOG2_MAX_PAGES-1:0] w_buf_id;
    logic [LOG2_MAX_PAGES-1:0] r_buf_id;
    logic [LOG2_MAX_PAGES-1:0] nevents;
    logic                      full;
    logic                      empty;
    logic                      bundle_ready;
    logic                      release_err;
    logic [DROP_W-1:0]         drop_count;

    modport master (
        output page_size, flush, commit, release_dma, release_sw, bundle_factor,
        input  w_buf_id, r_buf_id, nevents, full, empty, bundle_ready,
               release_err, drop_count
    );

    modport slave (
        input  page_size, flush, commit, release_dma, release_sw, bundle_factor,
        output w_buf_id, r_buf_id, nevents, full, empty, bundle_ready,
               release_err, drop_count
    );
endinterface

// File: rtl/daq_ring_ptr.sv
// Masked ring-pointer incrementer: adds one within the low mask bits,
// zeroes the upper bits and wraps N-1 back to 0.
//   ptr    : current pointer
//   mask   : low-bit wrap mask (N-1)
//   nxt_c  : combinational next pointer
module daq_ring_ptr #(
    parameter int unsigned W = 6
) (
    input  logic [W-1:0] ptr,
    input  logic [W-1:0] mask,
    output logic [W-1:0] nxt_c
);
    assign nxt_c = (ptr + W'(1)) & mask;
endmodule

// File: rtl/daq_page_scheduler.sv
// Ring-pointer controller for the DAQ event buffer. Tracks the page being
// written and the oldest unread page, arbitrates DMA/software releases,
// counts commits dropped on a full ring and flushes on request or on a
// page-size change.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : daq_page_scheduler_if slave (commands in, status out)
module daq_page_scheduler #(
    parameter int unsigned LOG2_MAX_PAGES = 6,
    parameter int unsigned DROP_W         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    daq_page_scheduler_if.slave   bus
);
    import daq_pkg::*;

    localparam int unsigned PW = LOG2_MAX_PAGES;

    state_t          state_q, state_d;
    logic [1:0]      ps_q;
    logic [PW-1:0]   w_q, w_d;
    logic [PW-1:0]   r_q, r_d;
    logic [PW-1:0]   nevents_q, nevents_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            bundle_q, bundle_d;
    logic            err_q, err_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [PW-1:0]   mask_q, mask_d;
    logic [PW-1:0]   w_inc_c, r_inc_c, w_look_c;
    logic            flush_req, pend, pend_d, serve;
    logic [3:0]      eff_bf;

    // Current ring uses the registered size; the lookahead uses the size
    // that will be in force after this edge.
    assign mask_q = PW'(n_pages_mask(ps_q));
    assign mask_d = PW'(n_pages_mask(bus.page_size));

    daq_ring_ptr #(.W(PW)) u_w_inc  (.ptr(w_q), .mask(mask_q), .nxt_c(w_inc_c));
    daq_ring_ptr #(.W(PW)) u_r_inc  (.ptr(r_q), .mask(mask_q), .nxt_c(r_inc_c));
    daq_ring_ptr #(.W(PW)) u_w_look (.ptr(w_d), .mask(mask_d), .nxt_c(w_look_c));

    // Next-state: flush, commit acceptance and release arbitration
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        r_d       = r_q;
        drop_d    = drop_q;
        err_d     = 1'b0;
        pend      = (state_q == ST_PEND);
        pend_d    = 1'b0;
        serve     = 1'b0;
        flush_req = bus.flush | (bus.page_size != ps_q);

        if (flush_req) begin
            state_d = ST_FLUSH;
            w_d     = '0;
            r_d     = '0;
        end else if (state_q == ST_FLUSH) begin
            state_d = ST_RUN;
        end else begin
            // full is judged at the start of the cycle; a same-cycle release does not help
            if (bus.commit) begin
                if (!full_q) begin
                    w_d = w_inc_c;
                end else if (drop_q != '1) begin
                    drop_d = drop_q + DROP_W'(1);
                end
            end

            // DMA first; a software release that cannot be served now is parked
            if (bus.release_dma) begin
                serve  = 1'b1;
                pend_d = pend | bus.release_sw;
            end else if (pend) begin
                serve  = 1'b1;
                pend_d = bus.release_sw;
            end else if (bus.release_sw) begin
                serve  = 1'b1;
            end

            if (serve) begin
                if (empty_q) begin
                    err_d = 1'b1;
                end else begin
                    r_d = r_inc_c;
                end
            end

            state_d = pend_d ? ST_PEND : ST_RUN;
        end
    end

    // Status derived from the next pointers so all flags move together
    always_comb begin
        eff_bf    = (bus.bundle_factor == 4'd0) ? 4'd1 : bus.bundle_factor;
        nevents_d = (w_d - r_d) & mask_d;
        empty_d   = (w_d == r_d);
        full_d    = (w_look_c == r_d);
        bundle_d  = (32'(nevents_d) >= 32'(eff_bf));
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            ps_q      <= PS_512;
            w_q       <= '0;
            r_q       <= '0;
            nevents_q <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            bundle_q  <= 1'b0;
            err_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            ps_q      <= bus.page_size;
            w_q       <= w_d;
            r_q       <= r_d;
            nevents_q <= nevents_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            bundle_q  <= bundle_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.w_buf_id     = w_q;
    assign bus.r_buf_id     = r_q;
    assign bus.nevents      = nevents_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.bundle_ready = bundle_q;
    assign bus.release_err  = err_q;
    assign bus.drop_count   = drop_q;

endmodule

// File: doc/daq_page_scheduler.md
# daq_page_scheduler

Ring-pointer controller for the 64-page DAQ event buffer. It tracks which page the link-side writer fills next and which page readout consumes next, in a single clock domain. It accepts end-of-event commits and release requests from DMA and software, and publishes full/empty/occupancy and a bundle-ready indication. The write manager, the buffer address builders and the DMA manager all take their page ids from this block.

## Interface
Parameters:
- LOG2_MAX_PAGES, default 6: pointer width; maximum ring is 64 pages.
- DROP_W, default 16: width of the saturating dropped-event counter.

Ports:
- clk  in  1  block clock.
- reset  in  1  asynchronous, active-high.
- page_size  in  2  0 gives 64 pages, 1 gives 32 pages, 2 or 3 gives 16 pages.
- flush  in  1  synchronous pulse; clears the ring.
- commit  in  1  end-of-event pulse from the writer.
- release_dma  in  1  pulse; DMA is finished with page r_buf_id.
- release_sw  in  1  pulse; software advance of the read page.
- bundle_factor  in  4  events required for bundle_ready; 0 is treated as 1.
- w_buf_id  out  6  page currently being written.
- r_buf_id  out  6  oldest unread page.
- nevents  out  6  (w_buf_id − r_buf_id) mod N.
- full  out  1  set when the next write page equals r_buf_id.
- empty  out  1  set when w_buf_id equals r_buf_id.
- bundle_ready  out  1  set when nevents ≥ effective bundle factor.
- release_err  out  1  one-cycle pulse when a release is attempted while empty.
- drop_count  out  DROP_W  commits rejected because the ring was full; saturates.

## Operation
- N = 64 >> min(page_size,2). One slot is always sacrificed, so maximum occupancy is N−1.
- Pointer increment:
  - adds 1 to the low log2(N) bits only;
  - forces the upper bits to 0;
  - wraps from N−1 to 0.
- page_size is registered internally as ps_q. If the sampled value differs from ps_q, the block performs an auto-flush in the same cycle ps_q updates.
- Commit:
  - accepted iff full=0 at the start of the cycle; w_buf_id then advances.
  - if full=1, the commit is rejected: w_buf_id holds and drop_count increments, saturating at all-ones.
  - a release in the same cycle does not rescue a commit made while full.
- Release arbitration:
  - release_dma has priority.
  - if release_sw arrives in the same cycle as release_dma, or while sw_pending is set, it sets sw_pending.
  - sw_pending is served on the first cycle with no release_dma.
  - at most one r_buf_id advance per cycle.
- Release with empty=1:
  - r_buf_id holds and release_err pulses.
  - a pending software release that finds the ring empty is discarded and also pulses release_err.
- Simultaneous commit and release, when not full: both pointers advance and nevents is unchanged.
- Flush (from the flush input or auto-flush):
  - w_buf_id, r_buf_id, nevents and sw_pending are cleared; empty=1.
  - drop_count is retained.
  - flush overrides commit and release in the same cycle.
- Control FSM, three states:
  - RUN is the normal state.
  - PEND is entered when sw_pending is set; it returns to RUN once the pending release is served or discarded.
  - FLUSH lasts one cycle, clears state, and then returns to RUN. Commits and releases during FLUSH are ignored, and no drop is counted.

## Timing
- All outputs are registered.
- Reset values: w_buf_id=0, r_buf_id=0, nevents=0, full=0, empty=1, bundle_ready=0, release_err=0, drop_count=0; FSM in RUN.
- Commit in cycle n: w_buf_id, nevents, full, empty and bundle_ready update at edge n+1, consistently in the same cycle.
- release_dma in cycle n: r_buf_id updates at n+1. A deferred release_sw updates at n+2 at the earliest.
- release_err asserts at n+1 for exactly one cycle.
- Flush or page_size change sampled in cycle n: all pointers read 0 at n+1 (through the FLUSH state), and the new N applies from n+1.
- Asynchronous reset mid-operation returns every output to its reset value immediately, with no pending state retained.

## Structure
- Shared package daq_pkg holds:
  - LOG2_MAX_PAGES;
  - page-size encodings PS_512/PS_1024/PS_2048;
  - function n_pages_mask(ps) returning the low-bit wrap mask;
  - the FSM state enumeration.
- One sub-module, daq_ring_ptr, is a masked incrementer with wrap. It is instantiated for the write pointer, the read pointer and the next-write lookahead used to compute full.

## Test plan
- Reset asserted then released, with no stimulus: w_buf_id=0, r_buf_id=0, empty=1, full=0, drop_count=0.
- page_size=0, 63 commits: full=1, nevents=63, w_buf_id=63. A 64th commit leaves w_buf_id=63 and sets drop_count=1.
- page_size=2, 15 commits: full=1. Then release_dma followed by a commit: r_buf_id=1 and w_buf_id wraps to 0, with nevents=15.
- nevents=3, release_dma and release_sw in the same cycle: r_buf_id=1 at n+1 and 2 at n+2; nevents=1; no release_err.
- Ring empty, release_sw pulse: r_buf_id unchanged and release_err high for one cycle.
- bundle_factor=4, commits one at a time: bundle_ready=0 at nevents=3 and 1 after the 4th commit. A page_size change from 0 to 1 then clears to w=r=0 and bundle_ready=0.
